subleq_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the SUBLEQ core; drives the subleq ALU
//  and consumes its result/branch outputs. Fetches {A,B,C} from program ROM,

---
 rtl/subleq_sequencer.sv | 121 ++++++++++++
 tb/tb_subleq_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_sequencer.sv
// Multi-cycle SUBLEQ control sequencer: fetches {A,B,C}, loads mem[A]/mem[B],
// writes the ALU result back to mem[B] and advances or branches the PC.
module subleq_sequencer #(
   parameter int unsigned             DATA_W   = 8,
   parameter int unsigned             ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic [ADDR_W-1:0]     pc,
   output logic [ADDR_W-1:0]     prog_addr,
   input  logic [3*ADDR_W-1:0]   prog_data,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     alu_reg_1,
   output logic [DATA_W-1:0]     alu_reg_2,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic                  alu_branch,
   output logic                  halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_LOAD_A,
      S_LOAD_B,
      S_EXEC,
      S_HALT
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   b_q, b_d;
   logic [ADDR_W-1:0]   c_q, c_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic                halted_q, halted_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         b_q      <= '0;
         c_q      <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         b_q      <= b_d;
         c_q      <= c_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      b_d       = b_q;
      c_d       = c_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      halted_d  = halted_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // A only addresses the first read, so it is taken straight off the ROM bus
            mem_addr = prog_data[2*ADDR_W +: ADDR_W];
            b_d      = prog_data[ADDR_W +: ADDR_W];
            c_d      = prog_data[0 +: ADDR_W];
            state_d  = S_LOAD_A;
         end
         S_LOAD_A: begin
            op1_d    = mem_rdata;
            mem_addr = b_q;
            state_d  = S_LOAD_B;
         end
         S_LOAD_B: begin
            op2_d   = mem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            mem_addr  = b_q;
            mem_wdata = alu_result;
            mem_we    = 1'b1;
            pc_d      = alu_branch ? c_q : pc_q + ADDR_W'(1);
            if (alu_branch && (c_q == pc_q)) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = run ? S_FETCH : S_IDLE;
            end
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   assign pc        = pc_q;
   assign prog_addr = pc_q;
   assign alu_reg_1 = op1_q;
   assign alu_reg_2 = op2_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: ROM/RAM/ALU environment plus an instruction-level
// SUBLEQ reference model driven by directed programs and random programs.
module tb_subleq_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  pc, prog_addr, mem_addr, mem_rdata, mem_wdata;
   logic [23:0] prog_data;
   logic        mem_we, alu_branch, halted;
   logic [7:0]  alu_reg_1, alu_reg_2, alu_result;
   logic signed [8:0] alu_diff;

   logic [23:0] rom  [256];
   logic [7:0]  ram  [256];
   logic [7:0]  mref [256];
   logic [7:0]  pref;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;

   subleq_sequencer #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .pc         (pc),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .alu_reg_1  (alu_reg_1),
      .alu_reg_2  (alu_reg_2),
      .alu_result (alu_result),
      .alu_branch (alu_branch),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      prog_data <= rom[prog_addr];
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
   end

   assign alu_result = alu_reg_2 - alu_reg_1;
   assign alu_diff   = $signed({alu_reg_2[7], alu_reg_2}) - $signed({alu_reg_1[7], alu_reg_1});
   assign alu_branch = alu_diff[8] || (alu_diff == 9'sd0);

   always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      pref  = 8'h00;
   endtask

   // leaves the DUT just inside its FETCH cycle
   task automatic start_run();
      @(negedge clk);
      run = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic exec_instr(input string tag, input bit rand_run, output bit hit_halt);
      logic [7:0] ia, ib, ic, va, vb, res, npc;
      int sd, n, we0;
      bit br;
      {ia, ib, ic} = rom[pref];
      va  = mref[ia];
      vb  = mref[ib];
      sd  = int'($signed(vb)) - int'($signed(va));
      br  = (sd <= 0);
      res = vb - va;
      npc = br ? ic : pref + 8'd1;
      hit_halt = br && (ic == pref);
      we0 = we_cnt;
      n = 0;
      while (n < 12) begin
         @(negedge clk);
         n++;
         if (mem_we) break;
         if (rand_run) run = 1'($urandom_range(0, 1));
      end
      check({tag, "_lat"}, n, 5);
      check({tag, "_addr"}, mem_addr, ib);
      check({tag, "_wdata"}, mem_wdata, res);
      check({tag, "_reg1"}, alu_reg_1, va);
      check({tag, "_reg2"}, alu_reg_2, vb);
      if (rand_run) run = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      check({tag, "_pc"}, pc, npc);
      check({tag, "_halted"}, halted, hit_halt);
      check({tag, "_we_once"}, we_cnt - we0, 1);
      mref[ib] = res;
      pref = npc;
   endtask

   initial begin
      bit h;
      int we0;

      // reset state
      for (int i = 0; i < 256; i++) begin
         rom[i] = '0;
         ram[i] = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 8'h00);
      check("rst_prog_addr", prog_addr, 8'h00);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, 8'h00);
      check("rst_wdata", mem_wdata, 8'h00);
      check("rst_halted", halted, 1'b0);
      reset = 1'b0;
      pref  = 8'h00;

      // directed program: jump to 0x10, then tests 1,2,3, jump to 0xFF, test 6
      rom[8'h00] = {8'h30, 8'h30, 8'h10};
      rom[8'h10] = {8'h31, 8'h32, 8'h00};
      rom[8'h11] = {8'h33, 8'h34, 8'h40};
      rom[8'h40] = {8'h35, 8'h36, 8'h00};
      rom[8'h41] = {8'h30, 8'h30, 8'hFF};
      rom[8'hFF] = {8'h37, 8'h38, 8'h00};
      ram[8'h31] = 8'd3;   ram[8'h32] = 8'd5;
      ram[8'h33] = 8'd5;   ram[8'h34] = 8'd5;
      ram[8'h35] = 8'h80;  ram[8'h36] = 8'h00;
      ram[8'h37] = 8'd1;   ram[8'h38] = 8'd3;
      for (int i = 0; i < 256; i++) mref[i] = ram[i];

      start_run();
      exec_instr("jmp10", 1'b0, h);
      exec_instr("t1", 1'b0, h);
      check("t1_mem", ram[8'h32], 8'h02);
      check("t1_pc", pc, 8'h11);
      exec_instr("t2", 1'b0, h);
      check("t2_mem", ram[8'h34], 8'h00);
      check("t2_pc", pc, 8'h40);
      exec_instr("t3", 1'b0, h);
      check("t3_mem", ram[8'h36], 8'h80);
      check("t3_pc", pc, 8'h41);
      exec_instr("jmpff", 1'b0, h);
      check("jmpff_pc", pc, 8'hFF);
      exec_instr("t6", 1'b0, h);
      check("t6_mem", ram[8'h38], 8'h02);
      check("t6_pc", pc, 8'h00);

      // reset abort in LOAD_B, then halt self-loop
      do_reset();
      rom[8'h00] = {8'h30, 8'h30, 8'h04};
      rom[8'h04] = {8'h20, 8'h20, 8'h04};
      ram[8'h20]  = 8'h55;
      mref[8'h20] = 8'h55;
      start_run();
      exec_instr("p2_jmp", 1'b0, h);
      we0 = we_cnt;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      run   = 1'b0;
      #1;
      check("t5_we", mem_we, 1'b0);
      check("t5_pc", pc, 8'h00);
      check("t5_addr", mem_addr, 8'h00);
      check("t5_wdata", mem_wdata, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      pref  = 8'h00;
      repeat (10) @(negedge clk);
      check("t5_no_we", we_cnt - we0, 0);
      check("t5_nowrite", ram[8'h20], 8'h55);
      check("t5_idle_pc", pc, 8'h00);
      start_run();
      exec_instr("p2_jmp2", 1'b0, h);
      exec_instr("t4", 1'b0, h);
      check("t4_hit", h, 1'b1);
      check("t4_mem", ram[8'h20], 8'h00);
      we0 = we_cnt;
      repeat (20) @(negedge clk);
      check("t4_no_we", we_cnt - we0, 0);
      check("t4_pc", pc, 8'h04);
      check("t4_halted", halted, 1'b1);

      // random programs with run toggling
      do_reset();
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 24'($urandom);
         ram[i]  = 8'($urandom);
         mref[i] = ram[i];
      end
      start_run();
      for (int k = 0; k < 150; k++) begin
         exec_instr("rnd", 1'b1, h);
         if (h) begin
            do_reset();
            start_run();
         end else if (!run) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rnd_idle_pc", pc, pref);
            start_run();
         end
      end
      for (int i = 0; i < 256; i++) begin
         if (ram[i] !== mref[i]) check("rnd_ram", ram[i], mref[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
